// File: rtl/fractcam_wr_sched.sv
// Round-robin row-write scheduler ahead of the fractcam update path; defers behind lookups up to MAX_DEFER cycles.
// Optional FRACTCAM_WR_SCHED_STATS_EN adds stat_wr_cnt / stat_defer_cnt counters.
module fractcam_wr_sched #(
    parameter  int NUM_REQ           = 4,
    parameter  int TCAM_DEPTH        = 1024,
    parameter  int TCAM_WR_WIDTH     = 128,
    parameter  int MAX_DEFER         = 16,
    localparam int SLICEM_ROWS       = TCAM_DEPTH / 8,
    localparam int SLICEM_ADDR_WIDTH = $clog2(SLICEM_ROWS),
    localparam int RW                = TCAM_WR_WIDTH * 8,
    localparam int GW                = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ*RW-1:0]                s_wr_data,
    input  logic [NUM_REQ*RW-1:0]                s_wr_keep,
    input  logic [NUM_REQ*SLICEM_ADDR_WIDTH-1:0] s_wr_addr,
    input  logic [NUM_REQ-1:0]                   s_wr_valid,
    output logic [NUM_REQ-1:0]                   s_wr_ready,
    input  logic                                 search_active,
    output logic [RW-1:0]                        m_wr_data,
    output logic [RW-1:0]                        m_wr_keep,
    output logic [SLICEM_ADDR_WIDTH-1:0]         m_wr_addr,
    output logic                                 m_wr_valid,
    input  logic                                 m_wr_ready,
    output logic                                 search_stall,
    output logic [GW-1:0]                        grant_id
`ifdef FRACTCAM_WR_SCHED_STATS_EN
    ,
    output logic [31:0]                          stat_wr_cnt,
    output logic [31:0]                          stat_defer_cnt
`endif
);

    localparam int DW = $clog2(MAX_DEFER + 1);
    localparam logic [DW-1:0] MAX_DEFER_C = DW'(MAX_DEFER);
    localparam logic [DW-1:0] DEFER_ONE_C = DW'(1);
    localparam logic [NUM_REQ-1:0] REQ_ONE_C = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_r;
    logic [GW-1:0]   rr_ptr_r;
    logic [DW-1:0]   defer_cnt_r;
    logic            any_valid_s;
    logic            grant_found_s;
    logic [GW-1:0]   grant_idx_s;
    logic [GW-1:0]   next_ptr_s;
    logic            go_s;

    // Requester index reached by stepping `offset` places from `base`, wrapping at NUM_REQ.
    function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int offset);
        int sum;
        sum = (int'(base) + offset) % NUM_REQ;
        return sum[GW-1:0];
    endfunction

    // Pick the first valid requester at or after the round-robin pointer.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {GW{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found_s && s_wr_valid[rr_index(rr_ptr_r, k)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = rr_index(rr_ptr_r, k);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Issue decision: a write goes when no lookup is pending or its deferral budget is spent.
    always_comb begin
        any_valid_s = |s_wr_valid;
        next_ptr_s  = rr_index(grant_idx_s, 1);
        go_s        = (state_r == ST_IDLE) && !rst && any_valid_s &&
                      (!search_active || (defer_cnt_r == MAX_DEFER_C));
        if (go_s) begin
            s_wr_ready = REQ_ONE_C << grant_idx_s;
        end else begin
            s_wr_ready = {NUM_REQ{1'b0}};
        end
    end

    // Scheduler FSM; all outbound write signals and the stall are registered with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= {GW{1'b0}};
            defer_cnt_r  <= {DW{1'b0}};
            grant_id     <= {GW{1'b0}};
            m_wr_valid   <= 1'b0;
            search_stall <= 1'b0;
            m_wr_data    <= {RW{1'b0}};
            m_wr_keep    <= {RW{1'b0}};
            m_wr_addr    <= {SLICEM_ADDR_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (go_s) begin
                        m_wr_data    <= s_wr_data[int'(grant_idx_s)*RW +: RW];
                        m_wr_keep    <= s_wr_keep[int'(grant_idx_s)*RW +: RW];
                        m_wr_addr    <= s_wr_addr[int'(grant_idx_s)*SLICEM_ADDR_WIDTH +: SLICEM_ADDR_WIDTH];
                        grant_id     <= grant_idx_s;
                        rr_ptr_r     <= next_ptr_s;
                        defer_cnt_r  <= {DW{1'b0}};
                        m_wr_valid   <= 1'b1;
                        search_stall <= 1'b1;
                        state_r      <= ST_SEND;
                    end else if (any_valid_s) begin
                        // Not going with a request pending means a lookup is holding us off.
                        if (defer_cnt_r < MAX_DEFER_C) begin
                            defer_cnt_r <= defer_cnt_r + DEFER_ONE_C;
                        end else begin
                            defer_cnt_r <= defer_cnt_r;
                        end
                    end else begin
                        defer_cnt_r <= {DW{1'b0}};
                    end
                end
                ST_SEND: begin
                    if (m_wr_ready) begin
                        m_wr_valid <= 1'b0;
                        state_r    <= ST_DRAIN;
                    end else begin
                        m_wr_valid <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (m_wr_ready) begin
                        search_stall <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        search_stall <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    m_wr_valid   <= 1'b0;
                    search_stall <= 1'b0;
                end
            endcase
        end
    end

`ifdef FRACTCAM_WR_SCHED_STATS_EN
    // Handshake and deferral counters; wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_wr_cnt    <= 32'd0;
            stat_defer_cnt <= 32'd0;
        end else begin
            if ((state_r == ST_SEND) && m_wr_ready) begin
                stat_wr_cnt <= stat_wr_cnt + 32'd1;
            end else begin
                stat_wr_cnt <= stat_wr_cnt;
            end
            if ((state_r == ST_IDLE) && !go_s && any_valid_s && search_active) begin
                stat_defer_cnt <= stat_defer_cnt + 32'd1;
            end else begin
                stat_defer_cnt <= stat_defer_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fractcam_wr_sched.sv
// Randomized scoreboard bench for fractcam_wr_sched against a behavioural grant/deferral model.
module tb_fractcam_wr_sched;
    localparam int N    = 4;
    localparam int MAXD = 16;
    localparam int RW   = 128 * 8;
    localparam int AW   = $clog2(1024 / 8);
    localparam int GW   = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    logic [N*RW-1:0] s_wr_data, s_wr_keep;
    logic [N*AW-1:0] s_wr_addr;
    logic [N-1:0]    s_wr_valid, s_wr_ready;
    logic            search_active, m_wr_valid, m_wr_ready, search_stall;
    logic [RW-1:0]   m_wr_data, m_wr_keep;
    logic [AW-1:0]   m_wr_addr;
    logic [GW-1:0]   grant_id;
`ifdef FRACTCAM_WR_SCHED_STATS_EN
    logic [31:0]     stat_wr_cnt, stat_defer_cnt;
`endif

    fractcam_wr_sched dut (
        .clk(clk), .rst(rst),
        .s_wr_data(s_wr_data), .s_wr_keep(s_wr_keep), .s_wr_addr(s_wr_addr),
        .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready),
        .search_active(search_active),
        .m_wr_data(m_wr_data), .m_wr_keep(m_wr_keep), .m_wr_addr(m_wr_addr),
        .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready),
        .search_stall(search_stall), .grant_id(grant_id)
`ifdef FRACTCAM_WR_SCHED_STATS_EN
        , .stat_wr_cnt(stat_wr_cnt), .stat_defer_cnt(stat_defer_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int            g;
        logic [AW-1:0] addr;
        logic [RW-1:0] data;
        logic [RW-1:0] keep;
    } row_t;

    row_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;
    bit   checking = 1'b0;

    // Behavioural model state: is a row owning the path, has it been taken by the update logic.
    bit   busy, sent;
    int   rr, defer, last_g, exp_wr, exp_def, g;
    bit   go;
    row_t held;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] one_v = 1;

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (low 128 bits) at %0t", nm, act[127:0], exp[127:0], $time);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (s_wr_valid[(rr + k) % N]) return (rr + k) % N;
        end
        return 0;
    endfunction

    // Reference model: predicts grants and output state every cycle from the current inputs.
    always @(negedge clk) begin
        if (checking) begin
            g  = pick();
            go = !rst && !busy && (|s_wr_valid) && (!search_active || defer == MAXD);
            exp_rdy = go ? (one_v << g) : '0;
            chk("s_wr_ready", s_wr_ready, exp_rdy);
            chk("m_wr_valid", m_wr_valid, busy && !sent);
            chk("search_stall", search_stall, busy);
            chk("grant_id", grant_id, last_g);
            chk("m_wr_addr_hold", m_wr_addr, held.addr);
            chk("m_wr_data_hold", m_wr_data, held.data);
            chk("m_wr_keep_hold", m_wr_keep, held.keep);
`ifdef FRACTCAM_WR_SCHED_STATS_EN
            chk("stat_wr_cnt", stat_wr_cnt, exp_wr);
            chk("stat_defer_cnt", stat_defer_cnt, exp_def);
`endif
            if (rst) begin
                busy = 0; sent = 0; rr = 0; defer = 0; last_g = 0;
                exp_wr = 0; exp_def = 0;
                held = '{0, '0, '0, '0};
                sb_q.delete();
            end else if (!busy) begin
                if (go) begin
                    held = '{g, s_wr_addr[g*AW +: AW], s_wr_data[g*RW +: RW], s_wr_keep[g*RW +: RW]};
                    sb_q.push_back(held);
                    last_g = g; rr = (g + 1) % N; defer = 0; busy = 1; sent = 0;
                end else if (|s_wr_valid) begin
                    if (defer < MAXD) defer++;
                    exp_def++;
                end else begin
                    defer = 0;
                end
            end else if (!sent) begin
                if (m_wr_ready) begin sent = 1; exp_wr++; end
            end else if (m_wr_ready) begin
                busy = 0;
            end
        end
    end

    // Scoreboard monitor: every accepted write must match the oldest predicted grant.
    always @(negedge clk) begin
        if (checking && !rst && m_wr_valid && m_wr_ready) begin
            if (sb_q.size() == 0) begin
                checks++; fails++;
                $display("FAIL sb_unexpected_write: got addr %0h required no write", m_wr_addr);
            end else begin
                row_t e;
                e = sb_q.pop_front();
                chk("sb_addr", m_wr_addr, e.addr);
                chk("sb_data", m_wr_data, e.data);
                chk("sb_keep", m_wr_keep, e.keep);
                chk("sb_grant_id", grant_id, e.g);
            end
        end
    end

    bit refill = 1'b0;
    logic [N-1:0] snap;

    task automatic new_row(input int i, input int addr);
        for (int w = 0; w < RW / 32; w++) begin
            s_wr_data[i*RW + w*32 +: 32] = $urandom();
            s_wr_keep[i*RW + w*32 +: 32] = $urandom();
        end
        s_wr_addr[i*AW +: AW] = AW'(addr);
        s_wr_valid[i] = 1'b1;
    endtask

    // One clock: accepted requesters drop valid or present a fresh row.
    task automatic tick();
        @(negedge clk);
        snap = s_wr_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (snap[i]) begin
                if (refill) new_row(i, $urandom_range(0, 127));
                else s_wr_valid[i] = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; search_active = 1'b0; m_wr_ready = 1'b1;
        s_wr_valid = '0; s_wr_data = '0; s_wr_keep = '0; s_wr_addr = '0;
        @(posedge clk); #1;
        checking = 1'b1;
        tick();
        rst = 1'b0;

        // Round robin from reset with all requesters continuously valid.
        refill = 1'b1;
        for (int i = 0; i < N; i++) new_row(i, $urandom_range(0, 127));
        repeat (16) tick();
        refill = 1'b0;
        s_wr_valid = '0;
        repeat (5) tick();

        // Single write from requester 1 to row 5.
        new_row(1, 5);
        repeat (6) tick();

        // Deferral behind continuous lookups until the budget saturates.
        search_active = 1'b1;
        new_row(0, $urandom_range(0, 127));
        repeat (22) tick();
        search_active = 1'b0;
        repeat (4) tick();

        // Backpressure from the update logic.
        m_wr_ready = 1'b0;
        new_row(2, $urandom_range(0, 127));
        repeat (12) tick();
        m_wr_ready = 1'b1;
        repeat (4) tick();

        // Reset while a row is in flight; requester 0 must win afterwards.
        m_wr_ready = 1'b0;
        new_row(3, $urandom_range(0, 127));
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_wr_ready = 1'b1;
        new_row(0, $urandom_range(0, 127));
        new_row(3, $urandom_range(0, 127));
        repeat (10) tick();

        // Random traffic, lookups and backpressure, with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) search_active = ~search_active;
            m_wr_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < N; i++) begin
                if (!s_wr_valid[i] && $urandom_range(0, 3) == 0) new_row(i, $urandom_range(0, 127));
                else if (s_wr_valid[i] && $urandom_range(0, 15) == 0) s_wr_valid[i] = 1'b0;
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; search_active = 1'b0; m_wr_ready = 1'b1; s_wr_valid = '0;
        repeat (8) tick();
        chk("sb_drained", sb_q.size(), 0);
        checking = 1'b0;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
